// File: rtl/receiver_word_fifo.sv
// receiver_word_fifo: packs received bytes into words and queues them in a FWFT FIFO with valid/ready output.
module receiver_word_fifo #(
    parameter int BYTE_W     = 8,
    parameter int WORD_BYTES = 4,
    parameter int DEPTH      = 4,
    parameter int BIG_ENDIAN = 1,
    parameter int TIMEOUT    = 0
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [BYTE_W-1:0]            data,
    input  logic                         valid,
    input  logic                         flush,
    output logic [BYTE_W*WORD_BYTES-1:0] out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         overflow,
    output logic                         frame_err
);
    localparam int WW = BYTE_W * WORD_BYTES;
    localparam int IW = $clog2(WORD_BYTES);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    logic [IW-1:0] r_idx, w_lane;
    logic [WW-1:0] r_acc, w_word, r_out_data, w_head_nxt;
    logic [WW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr, r_rd, w_rd_nxt;
    logic [CW-1:0] r_count, w_count_nxt;
    logic [TW-1:0] r_idle;
    logic          r_out_valid, r_overflow, r_frame_err;
    logic          w_clr, w_last, w_pop, w_full, w_push, w_drop, w_expire;

    always_comb begin
        w_clr       = RST || flush;
        w_lane      = BIG_ENDIAN != 0 ? IW'(WORD_BYTES - 1) - r_idx : r_idx;
        w_word      = r_acc;
        w_word[int'(w_lane) * BYTE_W +: BYTE_W] = data;
        w_last      = valid && r_idx == IW'(WORD_BYTES - 1);
        w_pop       = r_out_valid && out_ready;
        w_full      = r_count == CW'(DEPTH);
        w_push      = w_last && (!w_full || w_pop);
        w_drop      = w_last && w_full && !w_pop;
        w_expire    = TIMEOUT > 0 && !valid && r_idx != '0 && r_idle == TW'(TIMEOUT - 1);
        w_rd_nxt    = r_rd + AW'(w_pop);
        w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
        // Word being pushed lands directly on the head when it is the only entry after this edge
        w_head_nxt  = w_count_nxt == '0 ? '0 :
                      (w_push && r_wr == w_rd_nxt) ? w_word : r_mem[w_rd_nxt];
    end

    always_ff @(posedge CLK) begin
        if (w_clr) begin
            r_idx       <= '0;
            r_acc       <= '0;
            r_wr        <= '0;
            r_rd        <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
            r_idle      <= '0;
        end else begin
            if (valid) begin
                r_acc <= w_word;
                r_idx <= w_last ? '0 : r_idx + IW'(1);
            end else if (w_expire) begin
                r_idx <= '0;
            end
            r_idle      <= (valid || r_idx == '0 || w_expire) ? '0 : r_idle + TW'(1);
            if (w_push) r_wr <= r_wr + AW'(1);
            r_rd        <= w_rd_nxt;
            r_count     <= w_count_nxt;
            r_out_valid <= w_count_nxt != '0;
            r_out_data  <= w_head_nxt;
            r_overflow  <= r_overflow || w_drop;
            r_frame_err <= w_expire;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push && !w_clr) r_mem[r_wr] <= w_word;
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign frame_err = r_frame_err;
endmodule

// File: tb/tb_receiver_word_fifo.sv
// tb_receiver_word_fifo: directed table and sequence checks of the word-packing FIFO in four configurations.
module tb_receiver_word_fifo;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, flush = 1'b0, valid = 1'b0, ready = 1'b0;
    logic [7:0]  data = '0;
    logic [31:0] a_data, b_data, d_data;
    logic [15:0] c_data;
    logic [2:0]  a_cnt, b_cnt, c_cnt, d_cnt;
    logic        a_v, b_v, c_v, d_v, a_ovf, b_ovf, c_ovf, d_ovf, a_fe, b_fe, c_fe, d_fe;
    int          n_cmp = 0, n_bad = 0;

    receiver_word_fifo u_a (.CLK(clk), .RST(rst), .data(data), .valid(valid), .flush(flush),
        .out_data(a_data), .out_valid(a_v), .out_ready(ready), .count(a_cnt), .overflow(a_ovf), .frame_err(a_fe));
    receiver_word_fifo #(.BIG_ENDIAN(0)) u_b (.CLK(clk), .RST(rst), .data(data), .valid(valid), .flush(flush),
        .out_data(b_data), .out_valid(b_v), .out_ready(ready), .count(b_cnt), .overflow(b_ovf), .frame_err(b_fe));
    receiver_word_fifo #(.WORD_BYTES(2)) u_c (.CLK(clk), .RST(rst), .data(data), .valid(valid), .flush(flush),
        .out_data(c_data), .out_valid(c_v), .out_ready(ready), .count(c_cnt), .overflow(c_ovf), .frame_err(c_fe));
    receiver_word_fifo #(.TIMEOUT(16)) u_d (.CLK(clk), .RST(rst), .data(data), .valid(valid), .flush(flush),
        .out_data(d_data), .out_valid(d_v), .out_ready(ready), .count(d_cnt), .overflow(d_ovf), .frame_err(d_fe));

    typedef struct {
        logic        rst, fl, v, rdy;
        logic [7:0]  d;
        logic        ev;
        logic [31:0] ed;
        logic [2:0]  ec;
        logic        eo;
    } vec_t;
    vec_t        tbl[$];
    logic [31:0] ws [5] = '{32'h12345678, 32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4, 32'hD1D2D3D4};

    function automatic void add(input logic r, input logic f, input logic v, input logic rd, input logic [7:0] d,
                                input logic ev, input logic [31:0] ed, input logic [2:0] ec, input logic eo);
        vec_t t;
        t.rst = r; t.fl = f; t.v = v; t.rdy = rd; t.d = d;
        t.ev = ev; t.ed = ed; t.ec = ec; t.eo = eo;
        tbl.push_back(t);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_all();
        rst = 1'b1; flush = 1'b0; valid = 1'b0; ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d);
        valid = 1'b1; data = d;
        step();
        valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int j = 0; j < 4; j++) send_byte(w[(3 - j) * 8 +: 8]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        // Table: latency, fill to overflow with ready low, drain in order, flush.
        add(1, 0, 0, 0, 8'h00, 0, 32'h0, 3'd0, 0);
        for (int k = 0; k < 5; k++)
            for (int j = 0; j < 4; j++) begin
                int c;
                c = k + (j == 3 ? 1 : 0);
                if (c > 4) c = 4;
                add(0, 0, 1, 0, ws[k][(3 - j) * 8 +: 8], c > 0, c > 0 ? ws[0] : 32'h0, 3'(c), k == 4 && j == 3);
            end
        for (int i = 1; i <= 4; i++)
            add(0, 0, 0, 1, 8'h00, i < 4, i < 4 ? ws[i] : 32'h0, 3'(4 - i), 1);
        add(0, 1, 0, 0, 8'h00, 0, 32'h0, 3'd0, 0);

        foreach (tbl[i]) begin
            rst = tbl[i].rst; flush = tbl[i].fl; valid = tbl[i].v; ready = tbl[i].rdy; data = tbl[i].d;
            step();
            chk($sformatf("vec%0d out_valid", i), a_v, tbl[i].ev);
            chk($sformatf("vec%0d out_data", i), a_data, tbl[i].ed);
            chk($sformatf("vec%0d count", i), a_cnt, tbl[i].ec);
            chk($sformatf("vec%0d overflow", i), a_ovf, tbl[i].eo);
        end
        rst = 1'b0; flush = 1'b0; valid = 1'b0; ready = 1'b0;

        // Byte order and word width variants
        reset_all();
        send_word(32'h12345678);
        chk("le word", b_data, 32'h78563412);
        chk("le count", b_cnt, 3'd1);
        chk("w2 count", c_cnt, 3'd2);
        chk("w2 head", c_data, 16'h1234);
        reset_all();
        send_byte(8'hAB);
        send_byte(8'hCD);
        chk("w2 abcd", c_data, 16'hABCD);
        chk("w2 valid", c_v, 1'b1);

        // Push on full coincident with pop
        reset_all();
        for (int k = 0; k < 4; k++) send_word(ws[k]);
        chk("full count", a_cnt, 3'd4);
        send_byte(8'hE1); send_byte(8'hE2); send_byte(8'hE3);
        ready = 1'b1;
        send_byte(8'hE4);
        ready = 1'b0;
        chk("pushpop count", a_cnt, 3'd4);
        chk("pushpop ovf", a_ovf, 1'b0);
        chk("pushpop head", a_data, ws[1]);
        ready = 1'b1;
        step(); chk("drain1", a_data, ws[2]);
        step(); chk("drain2", a_data, ws[3]);
        step(); chk("drain3", a_data, 32'hE1E2E3E4);
        chk("drain3 count", a_cnt, 3'd1);
        step(); chk("drain4 valid", a_v, 1'b0);
        chk("drain4 data", a_data, 32'h0);
        ready = 1'b0;

        // Inter-byte timeout
        reset_all();
        send_byte(8'h11); send_byte(8'h22);
        idle(15);
        chk("to pre", d_fe, 1'b0);
        step();
        chk("to pulse", d_fe, 1'b1);
        step();
        chk("to end", d_fe, 1'b0);
        send_word(32'hDEADBEEF);
        chk("to word", d_data, 32'hDEADBEEF);
        chk("to count", d_cnt, 3'd1);
        chk("no-to word", a_data, 32'h1122DEAD);
        chk("no-to fe", a_fe, 1'b0);
        reset_all();
        send_byte(8'h33);
        idle(15);
        send_byte(8'h44);
        chk("to race fe", d_fe, 1'b0);
        send_byte(8'h55);
        chk("to race fe2", d_fe, 1'b0);
        send_byte(8'h66);
        chk("to race count", d_cnt, 3'd1);
        chk("to race word", d_data, 32'h33445566);

        // Reset mid-word with words queued, byte in the reset cycle discarded
        reset_all();
        send_word(ws[0]); send_word(ws[1]);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        rst = 1'b1; valid = 1'b1; data = 8'h04;
        step();
        rst = 1'b0; valid = 1'b0;
        chk("rst count", a_cnt, 3'd0);
        chk("rst valid", a_v, 1'b0);
        chk("rst data", a_data, 32'h0);
        send_word(32'h01020304);
        chk("rst clean", a_data, 32'h01020304);
        chk("rst clean count", a_cnt, 3'd1);

        // Flush after overflow
        reset_all();
        for (int k = 0; k < 5; k++) send_word(ws[k]);
        chk("fl pre ovf", a_ovf, 1'b1);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        flush = 1'b1; valid = 1'b1; data = 8'h99;
        step();
        flush = 1'b0; valid = 1'b0;
        chk("fl count", a_cnt, 3'd0);
        chk("fl valid", a_v, 1'b0);
        chk("fl ovf", a_ovf, 1'b0);
        chk("fl data", a_data, 32'h0);
        send_word(32'h55667788);
        chk("fl clean", a_data, 32'h55667788);
        chk("fl clean count", a_cnt, 3'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
